// File: rtl/alu_serial_op_decoder.sv
// Receiver for the ALU serial operation protocol: assembles data frames plus a
// closing command frame into one parallel operation with parity/framing/count checks.
module alu_serial_op_decoder #(
   parameter int MIN_ARGS = 2,
   parameter int MAX_ARGS = 10,
   parameter int DATA_W   = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               sin,
   output logic                               op_valid,
   output logic [DATA_W-1:0]                  op_cmd,
   output logic [MAX_ARGS*DATA_W-1:0]         op_args,
   output logic [$clog2(MAX_ARGS+1)-1:0]      op_arg_cnt,
   output logic                               err_data_par,
   output logic                               err_cmd_par,
   output logic                               err_arg_num,
   output logic                               err_frame
);

   localparam int ACNT_W = $clog2(MAX_ARGS + 1);
   localparam int BCNT_W = $clog2(DATA_W);
   localparam logic [ACNT_W-1:0] MAX_CNT  = ACNT_W'(MAX_ARGS);
   localparam logic [ACNT_W-1:0] MIN_CNT  = ACNT_W'(MIN_ARGS);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TYPE,
      S_PAYLOAD,
      S_PARITY,
      S_STOP,
      S_RESYNC
   } state_t;

   state_t                     state_q;
   logic [BCNT_W-1:0]          bit_cnt_q;
   logic                       is_cmd_q;
   logic [DATA_W-1:0]          shift_q;
   logic                       par_err_q;
   logic [ACNT_W-1:0]          arg_cnt_q;
   logic [MAX_ARGS*DATA_W-1:0] slots_q;
   logic                       ovf_q;
   logic                       dpar_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         is_cmd_q     <= 1'b0;
         shift_q      <= '0;
         par_err_q    <= 1'b0;
         arg_cnt_q    <= '0;
         slots_q      <= '0;
         ovf_q        <= 1'b0;
         dpar_q       <= 1'b0;
         op_valid     <= 1'b0;
         op_cmd       <= '0;
         op_args      <= '0;
         op_arg_cnt   <= '0;
         err_data_par <= 1'b0;
         err_cmd_par  <= 1'b0;
         err_arg_num  <= 1'b0;
         err_frame    <= 1'b0;
      end else begin
         op_valid  <= 1'b0;
         err_frame <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!sin) state_q <= S_TYPE;
            end
            S_TYPE: begin
               is_cmd_q  <= sin;
               bit_cnt_q <= '0;
               state_q   <= S_PAYLOAD;
            end
            S_PAYLOAD: begin
               shift_q   <= {shift_q[DATA_W-2:0], sin};
               bit_cnt_q <= bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) state_q <= S_PARITY;
            end
            S_PARITY: begin
               // Even parity: a correct parity bit cancels the payload XOR.
               par_err_q <= sin ^ (^shift_q);
               state_q   <= S_STOP;
            end
            S_STOP: begin
               if (sin) begin
                  if (is_cmd_q) begin
                     op_valid     <= 1'b1;
                     op_cmd       <= shift_q;
                     op_args      <= slots_q;
                     op_arg_cnt   <= arg_cnt_q;
                     err_data_par <= dpar_q;
                     err_cmd_par  <= par_err_q;
                     err_arg_num  <= (arg_cnt_q < MIN_CNT) | ovf_q;
                     arg_cnt_q    <= '0;
                     slots_q      <= '0;
                     ovf_q        <= 1'b0;
                     dpar_q       <= 1'b0;
                  end else begin
                     if (arg_cnt_q < MAX_CNT) begin
                        for (int i = 0; i < MAX_ARGS; i++) begin
                           if (arg_cnt_q == ACNT_W'(i)) slots_q[i*DATA_W +: DATA_W] <= shift_q;
                        end
                        arg_cnt_q <= arg_cnt_q + 1'b1;
                     end else begin
                        ovf_q <= 1'b1;
                     end
                     dpar_q <= dpar_q | par_err_q;
                  end
                  state_q <= S_IDLE;
               end else begin
                  // Framing error: the whole partial operation is untrustworthy.
                  err_frame <= 1'b1;
                  arg_cnt_q <= '0;
                  slots_q   <= '0;
                  ovf_q     <= 1'b0;
                  dpar_q    <= 1'b0;
                  state_q   <= S_RESYNC;
               end
            end
            S_RESYNC: begin
               if (sin) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_serial_op_decoder.md
Name: alu_serial_op_decoder

Overview:
Receiver end of the ALU serial operation protocol. It samples the single-wire input stream one bit per clock and assembles 2..10 data frames followed by one command frame into a parallel operation. It checks parity, framing and argument count, then presents the decoded operation with a one-cycle valid pulse to the ALU execution core.

Parameters:
MIN_ARGS, 2, minimum legal number of data frames per operation
MAX_ARGS, 10, maximum stored data frames; sets op_args width
DATA_W, 8, payload bits per frame

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sin  input  1  serial input; idle high; sampled every rising clk edge
op_valid  output  1  one-cycle pulse: decoded operation present
op_cmd  output  8  command payload of the completed operation
op_args  output  MAX_ARGS*DATA_W (80)  data bytes; byte i at [i*8 +: 8], first received at byte 0
op_arg_cnt  output  4  number of stored data bytes (0..MAX_ARGS)
err_data_par  output  1  at least one data frame had bad parity (valid with op_valid)
err_cmd_par  output  1  command frame had bad parity (valid with op_valid)
err_arg_num  output  1  data frame count < MIN_ARGS or > MAX_ARGS (valid with op_valid)
err_frame  output  1  one-cycle pulse: stop bit sampled 0, operation discarded

Behaviour:
- Frame: 11 bits, one per clk, in order: start (0), type (0 = data, 1 = command), 8 payload bits MSB first, parity, stop (1).
- Parity is even over the 8 payload bits. The correct parity bit equals the XOR of the payload.
- FSM states and transitions:
  - IDLE: waits for sin==0, then -> TYPE.
  - TYPE: latch type -> PAYLOAD.
  - PAYLOAD: 8 cycles, 3-bit counter, shift in -> PARITY.
  - PARITY: compare, latch mismatch -> STOP.
  - STOP: see below.
  - RESYNC: wait for sin==1 -> IDLE.
- STOP with sin==1, data frame:
  - If stored count < MAX_ARGS, write the byte at slot count and increment.
  - Otherwise set a sticky overflow flag and drop the byte.
  - OR the parity mismatch into the sticky data-parity flag.
  - -> IDLE.
- STOP with sin==1, command frame:
  - Register all op_* outputs and the error flags.
  - Pulse op_valid for exactly one cycle, starting at that clock edge.
  - Clear the accumulator (count, slots to 0, sticky flags) -> IDLE.
- STOP with sin==0:
  - Pulse err_frame for one cycle.
  - Discard the whole partial operation (accumulator cleared).
  - -> RESYNC. op_valid is not asserted.
- Back-to-back frames: a start bit in the cycle immediately after a stop bit is accepted; zero idle cycles are required. This includes the cycle in which op_valid is high.
- Output values:
  - err_arg_num = (count < MIN_ARGS) | overflow.
  - op_arg_cnt saturates at MAX_ARGS.
  - Unused op_args slots are 0.
- A command frame with zero preceding data frames still produces op_valid, with op_arg_cnt=0 and err_arg_num=1.
- op_cmd, op_args, op_arg_cnt and err_* hold their values between op_valid pulses.
- Parity errors never suppress op_valid; only framing errors discard an operation.
- Reset (asynchronous, any state, including mid-frame): all outputs 0, accumulator cleared, FSM -> IDLE. The first start bit is accepted on the first edge after rst_n deasserts.
- Latency: op_valid is high in the cycle following the edge that samples the command stop bit. That is 11 cycles after the command start bit is sampled.

Test Plan:
- Reset; send data 0x12, data 0x34, cmd 0x04, all with correct parity -> single op_valid pulse; op_args[15:0]=0x3412, upper bytes 0; op_arg_cnt=2; op_cmd=0x04; all err_* = 0.
- Send 10 data frames of 0xFF, then cmd 0x01 -> op_arg_cnt=10, op_args all 0xFF, err_arg_num=0. Repeat with 11 data frames -> op_arg_cnt=10, err_arg_num=1, 11th byte dropped.
- Send one data frame 0x00, then cmd 0x02 -> op_valid, op_arg_cnt=1, err_arg_num=1. Send cmd 0x02 alone -> op_arg_cnt=0, err_arg_num=1.
- Send data 0xA5 with parity bit 1 (correct is 0), data 0x01, then cmd 0x03 with parity bit 1 (correct is 0) -> op_valid, err_data_par=1, err_cmd_par=1, op_args[15:0]=0x01A5.
- Send data 0x55, then data 0x66 with stop bit 0 -> err_frame one-cycle pulse, no op_valid. Line returns high; send data 0x10, 0x20, cmd 0x05 -> op_args[15:0]=0x2010, op_arg_cnt=2, no 0x55 present.
- Drive rst_n low during the payload of the 2nd data frame, release after 3 cycles -> outputs 0 during reset. A following complete op (0xAA, 0xBB, cmd 0x06), sent back-to-back with no idle cycles, decodes with op_arg_cnt=2, op_args[15:0]=0xBBAA.
